// File: rtl/pipelined_control_unit.sv
// Decode / hazard / forwarding control for a classic 5-stage RV32I pipeline.
// Tracks EX, MEM and WB control state and steers operand forwarding.
module pipelined_control_unit #(
  parameter int REG_ADDR_W = 5,
  parameter int ENABLE_FWD = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  instr_valid,
  output logic                  instr_ready,
  input  logic [31:0]           instr,
  input  logic                  stall,
  input  logic                  flush,
  output logic                  ex_valid,
  output logic [19:0]           ex_ctrl,
  output logic [REG_ADDR_W-1:0] ex_rs1,
  output logic [REG_ADDR_W-1:0] ex_rs2,
  output logic [REG_ADDR_W-1:0] ex_rd,
  output logic [1:0]            fwd_a,
  output logic [1:0]            fwd_b,
  output logic                  mem_valid,
  output logic [2:0]            mem_ctrl,
  output logic [REG_ADDR_W-1:0] mem_rd,
  output logic                  wb_valid,
  output logic                  wb_write,
  output logic [REG_ADDR_W-1:0] wb_rd
);

  typedef struct packed {
    logic [2:0] func3;
    logic [3:0] alu_op;
    logic [1:0] next_pc_sel;
    logic [2:0] imm_sel;
    logic       alu_b_sel;
    logic [1:0] alu_a_sel;
    logic       illegal;
    logic       branch;
    logic       store;
    logic       load;
    logic       write;
  } ctrl_t;

  typedef enum logic [6:0] {
    OP_R      = 7'b0110011,
    OP_IMM    = 7'b0010011,
    OP_LOAD   = 7'b0000011,
    OP_STORE  = 7'b0100011,
    OP_BRANCH = 7'b1100011,
    OP_JAL    = 7'b1101111,
    OP_JALR   = 7'b1100111,
    OP_LUI    = 7'b0110111,
    OP_AUIPC  = 7'b0010111
  } opcode_e;

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_SLL = 4'd2, ALU_SLT = 4'd3, ALU_SLTU = 4'd4,
    ALU_XOR = 4'd5, ALU_SRL = 4'd6, ALU_SRA = 4'd7, ALU_OR  = 4'd8, ALU_AND  = 4'd9
  } alu_op_e;

  function automatic alu_op_e alu_from_f3(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  return alt ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  // x0 is hardwired, so it never creates a dependency.
  function automatic logic idx_hit(input logic [REG_ADDR_W-1:0] a, input logic [REG_ADDR_W-1:0] b);
    return (a != '0) && (a == b);
  endfunction

  logic [2:0]            f3;
  logic [REG_ADDR_W-1:0] dec_rs1, dec_rs2, dec_rd;
  ctrl_t                 dec_ctrl;
  logic                  rs1_used, rs2_used;
  logic                  hazard;
  logic                  unused_bits;

  logic                  ex_valid_q, ex_valid_d;
  ctrl_t                 ex_ctrl_q, ex_ctrl_d;
  logic [REG_ADDR_W-1:0] ex_rs1_q, ex_rs1_d, ex_rs2_q, ex_rs2_d, ex_rd_q, ex_rd_d;
  logic                  mem_valid_q, mem_valid_d;
  logic [2:0]            mem_ctrl_q, mem_ctrl_d;
  logic [REG_ADDR_W-1:0] mem_rd_q, mem_rd_d;
  logic                  wb_valid_q, wb_valid_d, wb_write_q, wb_write_d;
  logic [REG_ADDR_W-1:0] wb_rd_q, wb_rd_d;
  logic                  flush_pend_q, flush_pend_d;

  assign f3          = instr[14:12];
  assign dec_rs1     = REG_ADDR_W'(instr[19:15]);
  assign dec_rs2     = REG_ADDR_W'(instr[24:20]);
  assign dec_rd      = REG_ADDR_W'(instr[11:7]);
  assign unused_bits = ^{instr[31], instr[29:25]};

  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    dec_ctrl       = '0;
    dec_ctrl.func3 = f3;
    rs1_used       = 1'b1;
    rs2_used       = 1'b0;
    case (instr[6:0])
      OP_R: begin
        dec_ctrl.write  = 1'b1;
        dec_ctrl.alu_op = alu_from_f3(f3, instr[30]);
        rs2_used        = 1'b1;
      end
      OP_IMM: begin
        dec_ctrl.write     = 1'b1;
        dec_ctrl.alu_b_sel = 1'b1;
        dec_ctrl.alu_op    = alu_from_f3(f3, instr[30] && (f3 == 3'b101));
      end
      OP_LOAD: begin
        dec_ctrl.write     = 1'b1;
        dec_ctrl.load      = 1'b1;
        dec_ctrl.alu_b_sel = 1'b1;
      end
      OP_STORE: begin
        dec_ctrl.store     = 1'b1;
        dec_ctrl.alu_b_sel = 1'b1;
        dec_ctrl.imm_sel   = 3'd1;
        rs2_used           = 1'b1;
      end
      OP_BRANCH: begin
        dec_ctrl.branch      = 1'b1;
        dec_ctrl.imm_sel     = 3'd2;
        dec_ctrl.next_pc_sel = 2'd2;
        rs2_used             = 1'b1;
        case (f3[2:1])
          2'b00:   dec_ctrl.alu_op = ALU_SUB;
          2'b10:   dec_ctrl.alu_op = ALU_SLT;
          2'b11:   dec_ctrl.alu_op = ALU_SLTU;
          default: dec_ctrl.alu_op = ALU_ADD;
        endcase
      end
      OP_JAL: begin
        dec_ctrl.write       = 1'b1;
        dec_ctrl.alu_a_sel   = 2'd1;
        dec_ctrl.alu_b_sel   = 1'b1;
        dec_ctrl.imm_sel     = 3'd4;
        dec_ctrl.next_pc_sel = 2'd3;
        rs1_used             = 1'b0;
      end
      OP_JALR: begin
        dec_ctrl.write       = 1'b1;
        dec_ctrl.alu_b_sel   = 1'b1;
        dec_ctrl.next_pc_sel = 2'd1;
      end
      OP_LUI, OP_AUIPC: begin
        dec_ctrl.write     = 1'b1;
        dec_ctrl.alu_a_sel = (instr[6:0] == OP_LUI) ? 2'd2 : 2'd1;
        dec_ctrl.alu_b_sel = 1'b1;
        dec_ctrl.imm_sel   = 3'd3;
        rs1_used           = 1'b0;
      end
      default: dec_ctrl.illegal = 1'b1;
    endcase
  end

  always_comb begin
    hazard = ex_valid_q && ex_ctrl_q.load &&
             ((rs1_used && idx_hit(dec_rs1, ex_rd_q)) || (rs2_used && idx_hit(dec_rs2, ex_rd_q)));
    // Without forwarding, any in-flight producer ahead of WB blocks the consumer.
    if (ENABLE_FWD == 0) begin
      if (ex_valid_q && ex_ctrl_q.write &&
          ((rs1_used && idx_hit(dec_rs1, ex_rd_q)) || (rs2_used && idx_hit(dec_rs2, ex_rd_q))))
        hazard = 1'b1;
      if (mem_valid_q && mem_ctrl_q[0] &&
          ((rs1_used && idx_hit(dec_rs1, mem_rd_q)) || (rs2_used && idx_hit(dec_rs2, mem_rd_q))))
        hazard = 1'b1;
    end
  end

  always_comb begin
    fwd_a = 2'd0;
    fwd_b = 2'd0;
    if (ENABLE_FWD != 0) begin
      if (mem_valid_q && mem_ctrl_q[0] && idx_hit(ex_rs1_q, mem_rd_q))    fwd_a = 2'd1;
      else if (wb_valid_q && wb_write_q && idx_hit(ex_rs1_q, wb_rd_q))    fwd_a = 2'd2;
      if (mem_valid_q && mem_ctrl_q[0] && idx_hit(ex_rs2_q, mem_rd_q))    fwd_b = 2'd1;
      else if (wb_valid_q && wb_write_q && idx_hit(ex_rs2_q, wb_rd_q))    fwd_b = 2'd2;
    end
  end

  always_comb begin
    ex_valid_d   = ex_valid_q;
    ex_ctrl_d    = ex_ctrl_q;
    ex_rs1_d     = ex_rs1_q;
    ex_rs2_d     = ex_rs2_q;
    ex_rd_d      = ex_rd_q;
    mem_valid_d  = mem_valid_q;
    mem_ctrl_d   = mem_ctrl_q;
    mem_rd_d     = mem_rd_q;
    wb_valid_d   = wb_valid_q;
    wb_write_d   = wb_write_q;
    wb_rd_d      = wb_rd_q;
    flush_pend_d = flush_pend_q;
    if (stall) begin
      if (flush) flush_pend_d = 1'b1;
    end else begin
      flush_pend_d = 1'b0;
      mem_valid_d  = ex_valid_q;
      mem_ctrl_d   = {ex_ctrl_q.store, ex_ctrl_q.load, ex_ctrl_q.write};
      mem_rd_d     = ex_rd_q;
      wb_valid_d   = mem_valid_q;
      wb_write_d   = mem_ctrl_q[0];
      wb_rd_d      = mem_rd_q;
      if (flush || flush_pend_q || hazard || !instr_valid) begin
        ex_valid_d = 1'b0;
        ex_ctrl_d  = '0;
        ex_rs1_d   = '0;
        ex_rs2_d   = '0;
        ex_rd_d    = '0;
      end else begin
        ex_valid_d = 1'b1;
        ex_ctrl_d  = dec_ctrl;
        ex_rs1_d   = dec_rs1;
        ex_rs2_d   = dec_rs2;
        ex_rd_d    = dec_rd;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so all stages update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid_q   <= 1'b0;
      ex_ctrl_q    <= '0;
      ex_rs1_q     <= '0;
      ex_rs2_q     <= '0;
      ex_rd_q      <= '0;
      mem_valid_q  <= 1'b0;
      mem_ctrl_q   <= '0;
      mem_rd_q     <= '0;
      wb_valid_q   <= 1'b0;
      wb_write_q   <= 1'b0;
      wb_rd_q      <= '0;
      flush_pend_q <= 1'b0;
    end else begin
      ex_valid_q   <= ex_valid_d;
      ex_ctrl_q    <= ex_ctrl_d;
      ex_rs1_q     <= ex_rs1_d;
      ex_rs2_q     <= ex_rs2_d;
      ex_rd_q      <= ex_rd_d;
      mem_valid_q  <= mem_valid_d;
      mem_ctrl_q   <= mem_ctrl_d;
      mem_rd_q     <= mem_rd_d;
      wb_valid_q   <= wb_valid_d;
      wb_write_q   <= wb_write_d;
      wb_rd_q      <= wb_rd_d;
      flush_pend_q <= flush_pend_d;
    end
  end

  assign instr_ready = ~stall & ~hazard & ~rst;
  assign ex_valid    = ex_valid_q;
  assign ex_ctrl     = ex_ctrl_q;
  assign ex_rs1      = ex_rs1_q;
  assign ex_rs2      = ex_rs2_q;
  assign ex_rd       = ex_rd_q;
  assign mem_valid   = mem_valid_q;
  assign mem_ctrl    = mem_ctrl_q;
  assign mem_rd      = mem_rd_q;
  assign wb_valid    = wb_valid_q;
  assign wb_write    = wb_write_q;
  assign wb_rd       = wb_rd_q;

endmodule
